// File: rtl/pio_pkg.sv
// pio_pkg: register addresses and edge-type selectors for the parallel I/O port
package pio_pkg;
  localparam logic [2:0] PIO_DATA    = 3'd0;
  localparam logic [2:0] PIO_DIR     = 3'd1;
  localparam logic [2:0] PIO_IRQMASK = 3'd2;
  localparam logic [2:0] PIO_EDGE    = 3'd3;
  localparam logic [2:0] PIO_OUTSET  = 3'd4;
  localparam logic [2:0] PIO_OUTCLR  = 3'd5;
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;
endpackage

// File: rtl/pio_sync.sv
// pio_sync: multi-bit input synchroniser chain, async reset to zero
module pio_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] chain [STAGES];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)
      for (int k = 0; k < STAGES; k++) chain[k] <= '0;
    else begin
      chain[0] <= d;
      for (int k = 1; k < STAGES; k++) chain[k] <= chain[k-1];
    end
  assign q = chain[STAGES-1];
endmodule

// File: rtl/pio_bidir_n.sv
// pio_bidir_n: Avalon-MM bidirectional PIO with set/clear, edge capture and maskable irq
module pio_bidir_n
  import pio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               SYNC_STAGES = 2,
  parameter int               EDGE_TYPE   = EDGE_RISE,
  parameter logic [WIDTH-1:0] RESET_DIR   = '0,
  parameter logic [WIDTH-1:0] RESET_OUT   = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  inout  wire  [WIDTH-1:0] bidir_port
);
  logic [WIDTH-1:0] data_out, dir, irqmask, edge_cap, sync, prev, wd, rise, fall, edge_v, w1c;
  logic [2:0]       warm;
  logic             wr, armed, unused_wd;
  logic [31:0]      rd_mux;
  assign wr        = chipselect & ~write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;
  pio_sync #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .reset_n(reset_n), .d(bidir_port), .q(sync)
  );
  assign rise   = sync & ~prev;
  assign fall   = ~sync & prev;
  assign edge_v = EDGE_TYPE == EDGE_FALL ? fall : EDGE_TYPE == EDGE_ANY ? (rise | fall) : rise;
  // edges stay masked until the sync chain and prev hold real pin state
  assign armed  = warm == 3'(SYNC_STAGES + 1);
  assign w1c    = (wr && address == PIO_EDGE) ? wd : '0;
  assign rd_mux = address == PIO_DATA    ? 32'(sync)     :
                  address == PIO_DIR     ? 32'(dir)      :
                  address == PIO_IRQMASK ? 32'(irqmask)  :
                  address == PIO_EDGE    ? 32'(edge_cap) : '0;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      data_out <= RESET_OUT;
      dir      <= RESET_DIR;
      irqmask  <= '0;
      edge_cap <= '0;
      prev     <= '0;
      warm     <= '0;
      readdata <= '0;
    end else begin
      if (wr && address == PIO_DATA) data_out <= wd;
      else if (wr && address == PIO_OUTSET) data_out <= data_out | wd;
      else if (wr && address == PIO_OUTCLR) data_out <= data_out & ~wd;
      if (wr && address == PIO_DIR) dir <= wd;
      if (wr && address == PIO_IRQMASK) irqmask <= wd;
      edge_cap <= (edge_cap & ~w1c) | (armed ? edge_v : '0);
      prev     <= sync;
      warm     <= armed ? warm : warm + 3'd1;
      readdata <= rd_mux;
    end
  assign irq = |(edge_cap & irqmask);
  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    assign bidir_port[i] = dir[i] ? data_out[i] : 1'bz;
  end
endmodule

// File: tb/tb_pio_bidir_n.sv
// tb_pio_bidir_n: directed checks of a rising-edge and an any-edge PIO sharing one bus
module tb_pio_bidir_n;
  import pio_pkg::*;
  logic        clk = 1'b0, reset_n = 1'b0, chipselect = 1'b0, write_n = 1'b1;
  logic [2:0]  address = '0;
  logic [31:0] writedata = '0, rd_r, rd_a;
  logic        irq_r, irq_a;
  logic [7:0]  tb_oe = 8'hFF, tb_val = 8'h5A;
  wire  [7:0]  pins_r, pins_a;
  int          checks = 0, errors = 0;
  always #5 clk = ~clk;
  for (genvar i = 0; i < 8; i++) begin : g_drv
    assign pins_r[i] = tb_oe[i] ? tb_val[i] : 1'bz;
    assign pins_a[i] = tb_oe[i] ? tb_val[i] : 1'bz;
  end
  pio_bidir_n #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(EDGE_RISE)) u_r (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd_r), .irq(irq_r), .bidir_port(pins_r)
  );
  pio_bidir_n #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(EDGE_ANY)) u_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd_a), .irq(irq_a), .bidir_port(pins_a)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask
  task automatic rd(input logic [2:0] a);
    address = a;
    @(negedge clk);
  endtask
  initial begin
    #3;
    check("rst_rd", rd_r, 32'h0);
    check("rst_irq", {31'b0, irq_r}, 32'h0);
    cycles(2);
    reset_n = 1'b1;
    cycles(3);
    check("t1_data", rd_r, 32'h5A);
    rd(PIO_EDGE);
    check("t1_edge_r", rd_r, 32'h0);
    check("t1_edge_a", rd_a, 32'h0);
    rd(PIO_DIR);
    check("t1_dir", rd_r, 32'h0);
    check("t1_irq", {31'b0, irq_r | irq_a}, 32'h0);
    tb_val = 8'h00;
    cycles(4);
    wr(PIO_DIR, 32'hFF);
    tb_oe = 8'h00;
    wr(PIO_DATA, 32'hABCD_EF0F);
    wr(PIO_OUTSET, 32'h30);
    wr(PIO_OUTCLR, 32'h03);
    check("t2_pins", {24'b0, pins_r}, 32'h3C);
    cycles(3);
    rd(PIO_DATA);
    check("t2_data", rd_r, 32'h3C);
    rd(PIO_DIR);
    check("t2_dir", rd_r, 32'hFF);
    rd(PIO_OUTSET);
    check("t2_outset_rd", rd_r, 32'h0);
    rd(3'd6);
    check("t2_addr6", rd_r, 32'h0);
    wr(PIO_EDGE, 32'hFF);
    rd(PIO_EDGE);
    check("t2_edge_clr", rd_r, 32'h0);
    tb_val = 8'h3C; tb_oe = 8'hFF;
    wr(PIO_DIR, 32'h00);
    tb_val = 8'h00;
    cycles(5);
    wr(PIO_EDGE, 32'hFF);
    wr(PIO_IRQMASK, 32'h01);
    check("t3_irq_idle", {31'b0, irq_r}, 32'h0);
    tb_val = 8'h01;
    cycles(4);
    check("t3_irq_set", {31'b0, irq_r}, 32'h1);
    rd(PIO_EDGE);
    check("t3_edge", rd_r, 32'h01);
    wr(PIO_EDGE, 32'h01);
    check("t3_irq_clr", {31'b0, irq_r}, 32'h0);
    rd(PIO_EDGE);
    check("t3_edge_clr", rd_r, 32'h0);
    tb_val = 8'h03;
    cycles(2);
    wr(PIO_EDGE, 32'h02);
    rd(PIO_EDGE);
    check("t4_set_wins_r", rd_r, 32'h02);
    check("t4_set_wins_a", rd_a, 32'h02);
    check("t4_irq_masked", {31'b0, irq_r}, 32'h0);
    cycles(4);
    wr(PIO_EDGE, 32'hFF);
    wr(PIO_IRQMASK, 32'h00);
    tb_val = 8'h07; cycles(4);
    tb_val = 8'h03; cycles(4);
    tb_val = 8'h07; cycles(4);
    rd(PIO_EDGE);
    check("t5_edge_a", rd_a, 32'h04);
    check("t5_edge_r", rd_r, 32'h04);
    check("t5_irq_masked", {31'b0, irq_a}, 32'h0);
    wr(PIO_IRQMASK, 32'h04);
    check("t5_irq_unmask", {31'b0, irq_a}, 32'h1);
    wr(PIO_IRQMASK, 32'h00);
    check("t5_irq_remask", {31'b0, irq_a}, 32'h0);
    rd(PIO_EDGE);
    check("t5_edge_kept", rd_a, 32'h04);
    wr(PIO_DIR, 32'hFF);
    tb_oe = 8'h00;
    cycles(2);
    chipselect = 1'b1; write_n = 1'b0; address = PIO_DATA; writedata = 32'hFF;
    #2 reset_n = 1'b0;
    #1 tb_val = 8'h5A; tb_oe = 8'hFF;
    check("t6_rst_rd", rd_a, 32'h0);
    check("t6_rst_irq", {31'b0, irq_r | irq_a}, 32'h0);
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    reset_n = 1'b1;
    cycles(3);
    rd(PIO_DATA);
    check("t6_data", rd_r, 32'h5A);
    rd(PIO_DIR);
    check("t6_dir", rd_r, 32'h0);
    rd(PIO_IRQMASK);
    check("t6_mask", rd_r, 32'h0);
    rd(PIO_EDGE);
    check("t6_edge_a", rd_a, 32'h0);
    check("t6_edge_r", rd_r, 32'h0);
    tb_oe = 8'h00;
    wr(PIO_DIR, 32'hFF);
    check("t6_out_rst", {24'b0, pins_r}, 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
